ring_rr_arbiter: RTL and testbench

- Round-robin arbiter for N requesters sharing one resource.
- Priority is held in a one-hot ring token pointer that rotates one position past the last winner.
- Registered one-hot grant, done/release handshake, and a bounded hold time.
- Sits in front of any shared datapath resource (bus, ALU port, memory bank) and sequences access to it.

---
 rtl/ring_rr_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ring_rr_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ring_rr_arbiter
// Purpose  : Round-robin arbiter for N requesters sharing one resource.
//            A one-hot ring token (ptr) marks the highest-priority position
//            and moves to one past the last winner on every release. The
//            grant is registered and one-hot. One idle cycle always
//            separates two grants.
// Revision : 1.0 - initial release
// Macro    : HOLD_LIMIT_EN - when defined, a grant is force-released after
//            MAX_HOLD consecutive cycles and 'timeout' pulses for one cycle.
//            When undefined, a grant lasts until done[g] or req[g] drops,
//            and MAX_HOLD is accepted but has no effect.
// Ports    :
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous active-high reset
//   req          in   N  request vector, bit i = requester i wants access
//   done         in   N  release strobe, honoured only for the granted bit
//   grant        out  N  registered one-hot grant, or all zeros
//   grant_valid  out  1  registered OR of grant
//   ptr          out  N  one-hot priority token
//   timeout      out  1  one-cycle pulse on forced release (HOLD_LIMIT_EN)
// ============================================================================
module ring_rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic [N-1:0] done,
   output logic [N-1:0] grant,
   output logic         grant_valid,
   output logic [N-1:0] ptr
`ifdef HOLD_LIMIT_EN
   ,
   output logic         timeout
`endif
);

   localparam logic [0:0]   c_IDLE  = 1'b0;
   localparam logic [0:0]   c_GRANT = 1'b1;
   localparam logic [N-1:0] c_ONE   = {{(N-1){1'b0}}, 1'b1};

   // Reject illegal configurations at elaboration time.
   generate
      if (N < 2 || MAX_HOLD < 1) begin : g_bad_params
         $error("ring_rr_arbiter: requires N >= 2 and MAX_HOLD >= 1");
      end
   endgenerate

   logic [0:0]   state_q, state_d;
   logic [N-1:0] grant_q, grant_d;
   logic         gv_q, gv_d;
   logic [N-1:0] ptr_q, ptr_d;

   logic [N-1:0] w_req_hi;
   logic [N-1:0] w_win;
   logic         w_done_g;
   logic         w_req_g;
   logic         w_release;

`ifdef HOLD_LIMIT_EN
   localparam int              c_HW       = $clog2(MAX_HOLD + 1);
   localparam logic [c_HW-1:0] c_MAX_HOLD = c_HW'(MAX_HOLD);

   logic [c_HW-1:0] hold_q, hold_d;
   logic            timeout_q, timeout_d;
   logic            w_limit;
`endif

   // Winner search. (ptr - 1) sets every bit below the token, so its
   // complement masks req down to positions at or above the token. The lowest
   // set bit of that masked vector wins; if nothing sits at or above the
   // token, the search wraps to the lowest set bit of the full req vector.
   // x & (~x + 1) isolates the lowest set bit of x.
   always_comb begin
      w_req_hi = req & ~(ptr_q - c_ONE);
      if (|w_req_hi) begin
         w_win = w_req_hi & (~w_req_hi + c_ONE);
      end else begin
         w_win = req & (~req + c_ONE);
      end
   end

   // Only the granted requester's done/req bits can end a grant.
   always_comb begin
      w_done_g = |(grant_q & done);
      w_req_g  = |(grant_q & req);
`ifdef HOLD_LIMIT_EN
      w_limit   = (hold_q == c_MAX_HOLD);
      w_release = w_done_g | ~w_req_g | w_limit;
`else
      w_release = w_done_g | ~w_req_g;
`endif
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gv_d    = gv_q;
      ptr_d   = ptr_q;
`ifdef HOLD_LIMIT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         c_IDLE: begin
            if (|req) begin
               state_d = c_GRANT;
               grant_d = w_win;
               gv_d    = 1'b1;
`ifdef HOLD_LIMIT_EN
               hold_d  = c_HW'(1);
`endif
            end
         end
         c_GRANT: begin
            if (w_release) begin
               state_d = c_IDLE;
               grant_d = '0;
               gv_d    = 1'b0;
               // Token moves one position past the winner, wrapping N-1 -> 0.
               ptr_d   = {grant_q[N-2:0], grant_q[N-1]};
`ifdef HOLD_LIMIT_EN
               hold_d    = '0;
               // A release also caused by done or a dropped request is a
               // normal release, not a timeout.
               timeout_d = w_limit & ~w_done_g & w_req_g;
`endif
            end
`ifdef HOLD_LIMIT_EN
            else if (hold_q != c_MAX_HOLD) begin
               hold_d = hold_q + c_HW'(1);
            end
`endif
         end
         default: begin
            state_d = c_IDLE;
            grant_d = '0;
            gv_d    = 1'b0;
            ptr_d   = c_ONE;
`ifdef HOLD_LIMIT_EN
            hold_d  = '0;
`endif
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= c_IDLE;
         grant_q <= '0;
         gv_q    <= 1'b0;
         ptr_q   <= c_ONE;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gv_q    <= gv_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef HOLD_LIMIT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`endif

   assign grant       = grant_q;
   assign grant_valid = gv_q;
   assign ptr         = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_rr_arbiter
// Purpose  : Self-checking bench for ring_rr_arbiter (N=4, MAX_HOLD=8).
//            A behavioural model tracks the winner index, token index and
//            hold count as integers and is compared against the DUT on every
//            falling edge; directed sequences add literal expectations.
// Revision : 1.0 - initial release
// Macro    : HOLD_LIMIT_EN - selects the hold-limit expectations.
// ============================================================================
module tb_ring_rr_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;
`ifdef HOLD_LIMIT_EN
   localparam bit HOLD_EN  = 1'b1;
`else
   localparam bit HOLD_EN  = 1'b0;
`endif

   logic         clk;
   logic         reset;
   logic [N-1:0] req;
   logic [N-1:0] done;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic [N-1:0] ptr;
`ifdef HOLD_LIMIT_EN
   logic         timeout;
`endif

   int checks   = 0;
   int failures = 0;

   ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .ptr         (ptr)
`ifdef HOLD_LIMIT_EN
      ,
      .timeout     (timeout)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_ptr;    // index of the priority token
   int m_g;      // granted index, -1 when idle
   int m_hold;   // cycles the current grant has been high
   bit m_to;     // timeout pulse

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_ptr  = 0;
         m_g    = -1;
         m_hold = 0;
         m_to   = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_g < 0) begin
            for (int k = 0; k < N; k++) begin
               if (m_g < 0 && req[(m_ptr + k) % N]) begin
                  m_g    = (m_ptr + k) % N;
                  m_hold = 1;
               end
            end
         end else begin
            if (done[m_g] || !req[m_g] || (HOLD_EN && m_hold >= MAX_HOLD)) begin
               m_to   = HOLD_EN && (m_hold >= MAX_HOLD) && !done[m_g] && req[m_g];
               m_ptr  = (m_g + 1) % N;
               m_g    = -1;
               m_hold = 0;
            end else begin
               m_hold++;
            end
         end
      end
   end

   // Compare process: outputs against the model on every falling edge.
   always @(negedge clk) begin
      logic [N-1:0] eg;
      logic [N-1:0] ep;
      eg = '0;
      if (m_g >= 0) eg[m_g] = 1'b1;
      ep = '0;
      ep[m_ptr] = 1'b1;
      chk("model_grant", 32'(grant), 32'(eg));
      chk("model_grant_valid", 32'(grant_valid), 32'(m_g >= 0));
      chk("model_ptr", 32'(ptr), 32'(ep));
`ifdef HOLD_LIMIT_EN
      chk("model_timeout", 32'(timeout), 32'(m_to));
`endif
   end

   // ---------------- directed stimulus ----------------
   logic [N-1:0] seq [13];

   initial begin
      seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
              4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
      req   = '0;
      done  = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset_grant", 32'(grant), 32'h0);
      chk("reset_gv", 32'(grant_valid), 32'h0);
      chk("reset_ptr", 32'(ptr), 32'h1);

      // Full contention, each grant released on its second cycle.
      req = 4'b1111;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         chk("rr_seq", 32'(grant), 32'(seq[i]));
         done = (i > 0 && seq[i] != 0 && seq[i] == seq[i-1]) ? seq[i] : 4'b0000;
      end
      req  = '0;
      done = '0;
      @(negedge clk);
      chk("rr_seq_ptr", 32'(ptr), 32'h2);
      @(negedge clk);

      // Single requester 2, done on its third grant cycle.
      req = 4'b0100;
      @(negedge clk); chk("single_g1", 32'(grant), 32'h4);
      chk("single_gv", 32'(grant_valid), 32'h1);
      @(negedge clk); chk("single_g2", 32'(grant), 32'h4);
      @(negedge clk); chk("single_g3", 32'(grant), 32'h4);
      done = 4'b0100;
      @(negedge clk); chk("single_rel", 32'(grant), 32'h0);
      chk("single_ptr", 32'(ptr), 32'h8);
      done = '0;

      // Wrap-around from token 3.
      req = 4'b0011;
      @(negedge clk); chk("wrap_g", 32'(grant), 32'h1);
      done = 4'b0001;
      @(negedge clk); chk("wrap_rel", 32'(grant), 32'h0);
      chk("wrap_ptr", 32'(ptr), 32'h2);
      done = '0;
      @(negedge clk); chk("wrap_next", 32'(grant), 32'h2);
      done = 4'b0010;
      @(negedge clk); chk("wrap_ptr2", 32'(ptr), 32'h4);
      done = '0;
      req  = 4'b0001;

      // Non-granted done/req ignored; coincident done and req drop.
      @(negedge clk); chk("ign_g0", 32'(grant), 32'h1);
      done = 4'b0010; req = 4'b1001;
      @(negedge clk); chk("ign_g1", 32'(grant), 32'h1);
      done = 4'b0000; req = 4'b0001;
      @(negedge clk); chk("ign_g2", 32'(grant), 32'h1);
      done = 4'b0001; req = 4'b0000;
      @(negedge clk); chk("dual_rel", 32'(grant), 32'h0);
      chk("dual_ptr", 32'(ptr), 32'h2);
`ifdef HOLD_LIMIT_EN
      chk("dual_timeout", 32'(timeout), 32'h0);
`endif
      done = '0;

      // Held request with no done.
      req = 4'b0010;
`ifdef HOLD_LIMIT_EN
      for (int i = 0; i < MAX_HOLD; i++) begin
         @(negedge clk); chk("hold_g", 32'(grant), 32'h2);
      end
      @(negedge clk);
      chk("hold_idle", 32'(grant), 32'h0);
      chk("hold_timeout", 32'(timeout), 32'h1);
      chk("hold_ptr", 32'(ptr), 32'h4);
      @(negedge clk);
      chk("hold_regrant", 32'(grant), 32'h2);
      chk("hold_to_clr", 32'(timeout), 32'h0);
`else
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); chk("hold_g", 32'(grant), 32'h2);
      end
`endif
      req = '0;
      @(negedge clk);
      chk("hold_drop", 32'(grant), 32'h0);
      chk("hold_drop_ptr", 32'(ptr), 32'h4);

      // Asynchronous reset between edges while idle.
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("areset_idle_ptr", 32'(ptr), 32'h1);
      chk("areset_idle_gv", 32'(grant_valid), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Asynchronous reset between edges during a grant.
      req = 4'b1000;
      @(negedge clk); chk("pre_reset_g", 32'(grant), 32'h8);
      #2 reset = 1'b1;
      #1;
      chk("areset_grant", 32'(grant), 32'h0);
      chk("areset_gv", 32'(grant_valid), 32'h0);
      chk("areset_ptr", 32'(ptr), 32'h1);
`ifdef HOLD_LIMIT_EN
      chk("areset_timeout", 32'(timeout), 32'h0);
`endif
      @(negedge clk);
      reset = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
